text_field_renderer: RTL and testbench

- Scanline text engine that reads the 8x8 glyph ROM.
- On each active line that crosses a fixed on-screen text field, it fetches one glyph row per character and serializes it MSB-first into a per-pixel `pixel_on`, with integer pixel scaling.
- It sits between the VGA timing counters, the caller's character-slot lookup and the glyph ROM; `pixel_on` feeds the colour mux.

---
 rtl/text_field_renderer_if.sv | 25 ++
 rtl/text_field_renderer.sv | 151 +++++++++++++++
 tb/tb_text_field_renderer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/text_field_renderer_if.sv
// rtl/text_field_renderer_if.sv - glyph fetch bundle between renderer, character-slot lookup and glyph ROM
//   slot        : renderer -> caller, index of the character being fetched
//   char_code   : caller -> renderer, glyph code for slot (combinational)
//   rom_address : renderer -> ROM, {char_code, glyph_row}
//   rom_data    : ROM -> renderer, glyph row, bit7 = leftmost pixel
interface text_field_renderer_if;
    logic [2:0] slot;
    logic [4:0] char_code;
    logic [7:0] rom_address;
    logic [7:0] rom_data;

    modport master (
        output slot,
        output rom_address,
        input  char_code,
        input  rom_data
    );

    modport slave (
        input  slot,
        input  rom_address,
        output char_code,
        output rom_data
    );
endinterface

// File: rtl/text_field_renderer.sv
// rtl/text_field_renderer.sv - scanline text field engine serializing 8x8 glyph rows into pixel_on
//   clk          : pixel clock
//   rst_n        : asynchronous active-low reset
//   i_h_cnt      : horizontal pixel counter
//   i_v_cnt      : vertical line counter
//   i_active     : visible-area flag, aligned with i_h_cnt
//   glyph        : fetch bundle (slot out, char_code in, rom_address out, rom_data in)
//   o_pixel_on   : registered pixel, one clock after the h_cnt it represents
//   o_busy       : high while the engine is rendering (RUN)
//   Optional macro TEXT_BLINK_EN adds i_frame_tick / i_blink and a 5-bit frame
//   counter whose MSB blanks the field while i_blink is high.
module text_field_renderer #(
    parameter logic [9:0] X_START    = 10'd100,
    parameter logic [9:0] Y_START    = 10'd20,
    parameter int         NUM_CHARS  = 4,
    parameter int         SCALE_LOG2 = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [9:0]             i_h_cnt,
    input  logic [9:0]             i_v_cnt,
    input  logic                   i_active,
`ifdef TEXT_BLINK_EN
    input  logic                   i_frame_tick,
    input  logic                   i_blink,
`endif
    text_field_renderer_if.master  glyph,
    output logic                   o_pixel_on,
    output logic                   o_busy
);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    localparam logic [9:0] LP_ARM_H   = X_START - 10'd1;
    localparam logic [9:0] LP_FIELD_H = 10'(8 << SCALE_LOG2);
    localparam logic [1:0] LP_SUB_MAX = 2'((1 << SCALE_LOG2) - 1);
    localparam logic [3:0] LP_NCHARS  = 4'(NUM_CHARS);

    state_t     r_state, w_state_nxt;
    // One bit wider than the port: with NUM_CHARS=8 the slot must reach 8.
    logic [3:0] r_slot, w_slot_nxt;
    logic [7:0] r_shreg, w_shreg_nxt;
    logic [2:0] r_bit_cnt, w_bit_nxt;
    logic [1:0] r_sub_cnt, w_sub_nxt;
    logic       r_pixel_on, w_pix_nxt;

    logic [9:0] w_dv;
    logic [2:0] w_row;
    logic       w_in_field;
    logic       w_arm;
    logic       w_blank;

    // Lines above Y_START wrap to large values and fall out of the field.
    assign w_dv       = i_v_cnt - Y_START;
    assign w_in_field = (w_dv < LP_FIELD_H);
    assign w_row      = w_dv[SCALE_LOG2 +: 3];
    assign w_arm      = (i_h_cnt == LP_ARM_H) && w_in_field && i_active;

    assign glyph.rom_address = {glyph.char_code, w_row};
    assign glyph.slot        = r_slot[2:0];

`ifdef TEXT_BLINK_EN
    logic [4:0] r_frame_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= 5'd0;
        end else if (i_frame_tick) begin
            r_frame_cnt <= r_frame_cnt + 5'd1;
        end
    end

    assign w_blank = i_blink & r_frame_cnt[4];
`else
    assign w_blank = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_slot     <= 4'd0;
            r_shreg    <= 8'd0;
            r_bit_cnt  <= 3'd0;
            r_sub_cnt  <= 2'd0;
            r_pixel_on <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_slot     <= w_slot_nxt;
            r_shreg    <= w_shreg_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_sub_cnt  <= w_sub_nxt;
            r_pixel_on <= w_pix_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot;
        w_shreg_nxt = r_shreg;
        w_bit_nxt   = r_bit_cnt;
        w_sub_nxt   = r_sub_cnt;
        w_pix_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_slot_nxt = 4'd0;
                // Slot 0 is presented while idle, so its row is ready at X_START-1.
                if (w_arm) begin
                    w_shreg_nxt = glyph.rom_data;
                    w_slot_nxt  = 4'd1;
                    w_bit_nxt   = 3'd0;
                    w_sub_nxt   = 2'd0;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!i_active) begin
                    // Abort: drop the rest of the line; re-arm only at the next X_START-1.
                    w_state_nxt = ST_IDLE;
                    w_slot_nxt  = 4'd0;
                    w_shreg_nxt = 8'd0;
                end else begin
                    w_pix_nxt = r_shreg[7] & ~w_blank;
                    w_sub_nxt = r_sub_cnt + 2'd1;
                    if (r_sub_cnt == LP_SUB_MAX) begin
                        w_sub_nxt = 2'd0;
                        if (r_bit_cnt != 3'd7) begin
                            w_shreg_nxt = {r_shreg[6:0], 1'b0};
                            w_bit_nxt   = r_bit_cnt + 3'd1;
                        end else if (r_slot < LP_NCHARS) begin
                            // Next glyph loads on the last sub-pixel: no gap column.
                            w_shreg_nxt = glyph.rom_data;
                            w_slot_nxt  = r_slot + 4'd1;
                            w_bit_nxt   = 3'd0;
                        end else begin
                            w_state_nxt = ST_IDLE;
                            w_slot_nxt  = 4'd0;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_slot_nxt  = 4'd0;
            end
        endcase
    end

    assign o_pixel_on = r_pixel_on;
    assign o_busy     = (r_state == ST_RUN);

endmodule

// File: tb/tb_text_field_renderer.sv
// tb/tb_text_field_renderer.sv - self-checking bench for text_field_renderer
module tb_text_field_renderer;

    localparam int XS = 100;
    localparam int YS = 20;
    localparam int NC = 4;
    localparam int PX = 2;              // clocks / lines per glyph pixel
    localparam int CW = 8 * PX;         // clocks per character

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       active;
    logic       pixel_on;
    logic       busy;
`ifdef TEXT_BLINK_EN
    logic       frame_tick;
    logic       blink;
`endif

    logic [4:0] codes [0:7];
    logic [7:0] rom   [0:255];

    int checks = 0;
    int errors = 0;

    text_field_renderer_if gif ();

    assign gif.char_code = codes[gif.slot];
    assign gif.rom_data  = rom[gif.rom_address];

    always #5 clk = ~clk;

    text_field_renderer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_h_cnt      (h_cnt),
        .i_v_cnt      (v_cnt),
        .i_active     (active),
`ifdef TEXT_BLINK_EN
        .i_frame_tick (frame_tick),
        .i_blink      (blink),
`endif
        .glyph        (gif.master),
        .o_pixel_on   (pixel_on),
        .o_busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sweep one line; drop_h starts a 4-clock active-low window, rst_h a 3-clock reset.
    task automatic run_line(input logic [9:0] vv, input int drop_h, input int rst_h, input bit blank);
        logic [9:0] dv;
        bit infield, armed, killed, run;
        int row, off, idx, bitn, exp_slot;
        logic [7:0] grow;
        logic exp_pix, exp_busy;
        dv = vv - 10'(YS);
        infield = (int'(dv) < 8 * PX);
        row = (int'(dv) / PX) % 8;
        armed = 0;
        killed = 0;
        for (int hh = 90; hh <= 175; hh++) begin
            @(negedge clk);
            h_cnt  = 10'(hh);
            v_cnt  = vv;
            active = !(drop_h >= 0 && hh >= drop_h && hh < drop_h + 4);
            rst_n  = !(rst_h >= 0 && hh >= rst_h && hh < rst_h + 3);
            if (hh == rst_h) begin
                #1;
                chk("rst_async_pix", {31'd0, pixel_on}, 32'd0);
                chk("rst_async_busy", {31'd0, busy}, 32'd0);
                chk("rst_async_slot", {29'd0, gif.slot}, 32'd0);
            end
            if (hh == XS - 1) armed = infield && active && rst_n;
            if (hh >= XS && (!active || !rst_n)) killed = 1;
            @(posedge clk);
            #1;
            run = armed && !killed;
            exp_busy = run && hh >= XS - 1 && hh <= XS + NC * CW - 2;
            exp_slot = exp_busy ? 1 + (hh - (XS - 1)) / CW : 0;
            exp_pix = 1'b0;
            if (run && hh >= XS && hh <= XS + NC * CW - 1 && !blank) begin
                off  = hh - XS;
                idx  = off / CW;
                bitn = (off / PX) % 8;
                grow = rom[int'(codes[idx]) * 8 + row];
                exp_pix = grow[7 - bitn];
            end
            chk($sformatf("pix v=%0d h=%0d", vv, hh), {31'd0, pixel_on}, {31'd0, exp_pix});
            chk($sformatf("busy v=%0d h=%0d", vv, hh), {31'd0, busy}, {31'd0, exp_busy});
            chk($sformatf("slot v=%0d h=%0d", vv, hh), {29'd0, gif.slot}, 32'(exp_slot));
        end
        @(negedge clk);
        rst_n  = 1'b1;
        active = 1'b0;
        h_cnt  = 10'd0;
    endtask

`ifdef TEXT_BLINK_EN
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
        end
    endtask
`endif

    initial begin
        for (int a = 0; a < 256; a++) rom[a] = (a >= 22 * 8) ? 8'h00 : 8'($urandom);
        rom[0]   = 8'h1E;
        rom[8]   = 8'h02;
        rom[128] = 8'h08;
        for (int i = 0; i < 8; i++) codes[i] = 5'd0;
        rst_n  = 1'b0;
        h_cnt  = 10'd50;
        v_cnt  = 10'd20;
        active = 1'b1;
`ifdef TEXT_BLINK_EN
        frame_tick = 1'b0;
        blink      = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pix", {31'd0, pixel_on}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_slot", {29'd0, gif.slot}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_no_arm", {31'd0, busy}, 32'd0);

        // Single glyph row: '0' row 0 doubled
        #1;
        chk("rom_addr_v20", {24'd0, gif.rom_address}, 32'd0);
        run_line(10'd20, -1, -1, 1'b0);

        // Row mapping
        codes[0] = 5'd1;
        @(negedge clk);
        v_cnt = 10'd24;
        #1;
        chk("rom_addr_v24", {24'd0, gif.rom_address}, 32'd10);
        v_cnt = 10'd25;
        #1;
        chk("rom_addr_v25", {24'd0, gif.rom_address}, 32'd10);
        run_line(10'd24, -1, -1, 1'b0);
        run_line(10'd25, -1, -1, 1'b0);
        run_line(10'd36, -1, -1, 1'b0);
        run_line(10'd19, -1, -1, 1'b0);
        run_line(10'd35, -1, -1, 1'b0);

        // Character boundary and end of field
        codes[1] = 5'd16;
        codes[2] = 5'd3;
        codes[3] = 5'd7;
        run_line(10'd20, -1, -1, 1'b0);

        // Abort at h=130, then reset mid-line
        run_line(10'd21, 130, -1, 1'b0);
        run_line(10'd22, -1, 120, 1'b0);
        run_line(10'd22, -1, -1, 1'b0);
        // Not active at arm point
        run_line(10'd23, 97, -1, 1'b0);

        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < 8; i++) codes[i] = 5'($urandom_range(0, 31));
            run_line(10'($urandom_range(10, 45)),
                     ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(100, 170)),
                     -1, 1'b0);
        end

`ifdef TEXT_BLINK_EN
        for (int i = 0; i < 4; i++) codes[i] = 5'($urandom_range(0, 21));
        blink = 1'b1;
        ticks(16);
        run_line(10'd26, -1, -1, 1'b1);
        ticks(16);
        run_line(10'd26, -1, -1, 1'b0);
        blink = 1'b0;
        ticks(16);
        run_line(10'd27, -1, -1, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
